// File: rtl/alu_acc_pkg.sv
// Shared types and flag layout for the accumulator ALU.
package alu_acc_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBB = 4'd3,
    OP_AND = 4'd4,
    OP_XOR = 4'd5,
    OP_OR  = 4'd6,
    OP_CMP = 4'd7,
    OP_INC = 4'd8,
    OP_DEC = 4'd9,
    OP_RRC = 4'd10,
    OP_RLC = 4'd11,
    OP_MUL = 4'd12
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_AC = 4;
  localparam int FLAG_P  = 2;
  localparam int FLAG_CY = 0;

  // Bits 5, 3 and 1 of the flag register are hard zero.
  localparam logic [7:0] FLAG_MASK = 8'hD5;

  function automatic logic [7:0] mk_flags(input logic s, input logic z, input logic ac,
                                          input logic p, input logic cy);
    logic [7:0] f;
    f          = '0;
    f[FLAG_S]  = s;
    f[FLAG_Z]  = z;
    f[FLAG_AC] = ac;
    f[FLAG_P]  = p;
    f[FLAG_CY] = cy;
    return f;
  endfunction

endpackage

// File: rtl/alu_acc_comb.sv
// Single-cycle ALU: result and next flags from the latched operands; MUL and
// codes 13-15 report no writeback.
module alu_acc_comb
  import alu_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] act,
  input  logic [WIDTH-1:0] tmp,
  input  logic [3:0]       op,
  input  logic [7:0]       flags,
  output logic [WIDTH-1:0] result,
  output logic [7:0]       flags_next,
  output logic             acc_wr,
  output logic             flags_wr
);

  logic [WIDTH-1:0] rhs;
  logic [WIDTH:0]   sum;
  logic             cy_in;
  logic             arith;
  logic             logic_op;
  logic             keep_cy;
  logic             cy_out;
  logic             ac;

  always_comb begin
    rhs        = tmp;
    sum        = '0;
    arith      = 1'b0;
    logic_op   = 1'b0;
    keep_cy    = 1'b0;
    result     = act;
    acc_wr     = 1'b1;
    flags_wr   = 1'b1;
    flags_next = flags;
    cy_in      = flags[FLAG_CY];

    case (op)
      OP_ADD: begin
        sum   = {1'b0, act} + {1'b0, tmp};
        arith = 1'b1;
      end
      OP_ADC: begin
        sum   = {1'b0, act} + {1'b0, tmp} + {{WIDTH{1'b0}}, cy_in};
        arith = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        sum    = {1'b0, act} - {1'b0, tmp};
        arith  = 1'b1;
        acc_wr = (op != OP_CMP);
      end
      OP_SBB: begin
        sum   = {1'b0, act} - {1'b0, tmp} - {{WIDTH{1'b0}}, cy_in};
        arith = 1'b1;
      end
      OP_AND: begin
        result   = act & tmp;
        logic_op = 1'b1;
      end
      OP_XOR: begin
        result   = act ^ tmp;
        logic_op = 1'b1;
      end
      OP_OR: begin
        result   = act | tmp;
        logic_op = 1'b1;
      end
      OP_INC: begin
        rhs     = WIDTH'(1);
        sum     = {1'b0, act} + {1'b0, rhs};
        arith   = 1'b1;
        keep_cy = 1'b1;
      end
      OP_DEC: begin
        rhs     = WIDTH'(1);
        sum     = {1'b0, act} - {1'b0, rhs};
        arith   = 1'b1;
        keep_cy = 1'b1;
      end
      OP_RRC: begin
        result              = {act[0], act[WIDTH-1:1]};
        flags_next[FLAG_CY] = act[0];
      end
      OP_RLC: begin
        result              = {act[WIDTH-2:0], act[WIDTH-1]};
        flags_next[FLAG_CY] = act[WIDTH-1];
      end
      default: begin
        acc_wr   = 1'b0;
        flags_wr = 1'b0;
      end
    endcase

    if (arith) result = sum[WIDTH-1:0];
    // Top bit of the extended sum is the carry for adds and the borrow for subtracts.
    cy_out = keep_cy ? flags[FLAG_CY] : sum[WIDTH];
    // Carry (or borrow) into bit 4 recovered from the bit-4 operands and result.
    ac     = act[4] ^ rhs[4] ^ result[4];

    if (arith)
      flags_next = mk_flags(result[WIDTH-1], result == '0, ac, ~^result, cy_out);
    else if (logic_op)
      flags_next = mk_flags(result[WIDTH-1], result == '0, 1'b0, ~^result, 1'b0);
  end

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator ALU sequencer: 2-cycle single ops, WIDTH+1-cycle shift-add MUL.
// start/acc_we/flag_we are honoured only while idle; requests during busy are dropped.
module alu_acc_seq
  import alu_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             src_sel,
  input  logic [WIDTH-1:0] dbus_in,
  input  logic             acc_we,
  input  logic             flag_we,
  input  logic [7:0]       flag_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] prod_lo,
  output logic [7:0]       flags_out
);

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   act;
  logic [WIDTH-1:0]   tmp;
  logic [WIDTH-1:0]   prod_lo_r;
  logic [7:0]         flags;
  logic [3:0]         op_r;
  logic [2*WIDTH-1:0] part;
  logic               done_r;

  logic [WIDTH-1:0]   alu_res;
  logic [7:0]         alu_flags;
  logic               alu_acc_wr;
  logic               alu_flags_wr;

  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   mul_hi;
  logic [WIDTH-1:0]   mul_lo;
  logic               mul_last;

  alu_acc_comb #(.WIDTH(WIDTH)) u_comb (
    .act        (act),
    .tmp        (tmp),
    .op         (op_r),
    .flags      (flags),
    .result     (alu_res),
    .flags_next (alu_flags),
    .acc_wr     (alu_acc_wr),
    .flags_wr   (alu_flags_wr)
  );

  // One multiplier bit per cycle: add act shifted to the weight of tmp[cnt].
  always_comb begin
    addend   = tmp[cnt] ? ({{WIDTH{1'b0}}, act} << cnt) : '0;
    prod_nxt = part + addend;
    mul_hi   = prod_nxt[2*WIDTH-1:WIDTH];
    mul_lo   = prod_nxt[WIDTH-1:0];
    mul_last = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (op == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_nxt = ST_IDLE;
      ST_MUL:  if (mul_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      act       <= '0;
      tmp       <= '0;
      prod_lo_r <= '0;
      flags     <= '0;
      op_r      <= '0;
      part      <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acc_we)  acc   <= dbus_in;
          if (flag_we) flags <= flag_in & FLAG_MASK;
          if (start) begin
            act  <= src_sel ? acc : dbus_in;
            tmp  <= dbus_in;
            op_r <= op;
            cnt  <= '0;
            part <= '0;
          end
        end
        ST_EXEC: begin
          if (alu_acc_wr)   acc   <= alu_res;
          if (alu_flags_wr) flags <= alu_flags;
          done_r <= 1'b1;
        end
        ST_MUL: begin
          part <= prod_nxt;
          cnt  <= cnt + CW'(1);
          if (mul_last) begin
            acc       <= mul_hi;
            prod_lo_r <= mul_lo;
            flags     <= mk_flags(mul_hi[WIDTH-1], prod_nxt == '0, 1'b0, ~^mul_hi, |mul_hi);
            cnt       <= '0;
            done_r    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = done_r;
  assign acc_out   = acc;
  assign prod_lo   = prod_lo_r;
  assign flags_out = flags;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Scoreboard bench for alu_acc_seq at WIDTH=8: expectations queued at issue, checked on done.
module tb_alu_acc_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] op;
  logic       src_sel;
  logic [7:0] dbus_in;
  logic       acc_we;
  logic       flag_we;
  logic [7:0] flag_in;
  logic       busy;
  logic       done;
  logic [7:0] acc_out;
  logic [7:0] prod_lo;
  logic [7:0] flags_out;

  alu_acc_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .src_sel   (src_sel),
    .dbus_in   (dbus_in),
    .acc_we    (acc_we),
    .flag_we   (flag_we),
    .flag_in   (flag_in),
    .busy      (busy),
    .done      (done),
    .acc_out   (acc_out),
    .prod_lo   (prod_lo),
    .flags_out (flags_out)
  );

  typedef struct {
    logic [7:0] acc;
    logic [7:0] prod;
    logic [7:0] flags;
    int         lat;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  logic [7:0] m_acc   = 8'h00;
  logic [7:0] m_prod  = 8'h00;
  logic [7:0] m_flags = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference behaviour in plain integer arithmetic; updates the model registers.
  task automatic push_model(input logic [3:0] o, input logic ss, input logic [7:0] d,
                            input logic fwe, input logic [7:0] fin);
    exp_t        e;
    int          a, b, ci, r;
    logic [7:0]  av, res;
    logic [15:0] p;
    logic        cy, ac, full;
    av = ss ? m_acc : d;
    a  = av;
    b  = d;
    if (fwe) m_flags = fin & 8'hD5;
    ci   = m_flags[0];
    cy   = m_flags[0];
    ac   = 1'b0;
    full = 1'b0;
    res  = 8'h00;
    case (o)
      0, 1: begin
        if (o == 0) ci = 0;
        r = a + b + ci; res = r[7:0]; cy = (r > 255);
        ac = ((a % 16) + (b % 16) + ci) > 15; full = 1'b1; m_acc = res;
      end
      2, 3, 7: begin
        if (o != 3) ci = 0;
        r = a - b - ci; res = r[7:0]; cy = (r < 0);
        ac = ((a % 16) - (b % 16) - ci) < 0; full = 1'b1;
        if (o != 7) m_acc = res;
      end
      4, 5, 6: begin
        res = (o == 4) ? (av & d) : (o == 5) ? (av ^ d) : (av | d);
        cy = 1'b0; ac = 1'b0; full = 1'b1; m_acc = res;
      end
      8: begin r = a + 1; res = r[7:0]; ac = ((a % 16) == 15); full = 1'b1; m_acc = res; end
      9: begin r = a - 1; res = r[7:0]; ac = ((a % 16) == 0);  full = 1'b1; m_acc = res; end
      10: begin m_acc = {av[0], av[7:1]}; m_flags[0] = av[0]; end
      11: begin m_acc = {av[6:0], av[7]}; m_flags[0] = av[7]; end
      12: begin
        p = {8'h00, av} * {8'h00, d};
        m_acc = p[15:8]; m_prod = p[7:0];
        m_flags = {p[15], p == 16'h0, 1'b0, 1'b0, 1'b0, ~^p[15:8], 1'b0, p[15:8] != 8'h00};
      end
      default: ;
    endcase
    if (full) m_flags = {res[7], res == 8'h00, 1'b0, ac, 1'b0, ~^res, 1'b0, cy};
    e.acc   = m_acc;
    e.prod  = m_prod;
    e.flags = m_flags;
    e.lat   = (o == 12) ? 9 : 2;
    e.cyc   = cyc;
    sb_q.push_back(e);
  endtask

  // Returns at #1 after the edge that raises done, so a follow-up start is back-to-back.
  task automatic issue(input logic [3:0] o, input logic ss, input logic [7:0] d,
                       input logic fwe = 1'b0, input logic [7:0] fin = 8'h00,
                       input logic poke = 1'b0);
    int lat, nb;
    push_model(o, ss, d, fwe, fin);
    lat = (o == 12) ? 9 : 2;
    start = 1'b1; op = o; src_sel = ss; dbus_in = d; flag_we = fwe; flag_in = fin;
    @(posedge clk); #1;
    start = 1'b0; flag_we = 1'b0; dbus_in = 8'($urandom);
    nb = 0;
    for (int i = 1; i < lat; i++) begin
      nb += int'(busy);
      if (poke && i == 3) begin
        start = 1'b1; op = 4'd0; acc_we = 1'b1; flag_we = 1'b1; flag_in = 8'hFF; dbus_in = 8'h5A;
      end
      @(posedge clk); #1;
      start = 1'b0; acc_we = 1'b0; flag_we = 1'b0;
    end
    check_eq("busy_cycles", 16'(nb), 16'(lat - 1));
    check_eq("busy_end", {15'h0, busy}, 16'h0);
  endtask

  task automatic load_acc(input logic [7:0] d);
    acc_we = 1'b1; dbus_in = d;
    @(posedge clk); #1;
    acc_we = 1'b0;
    m_acc = d;
  endtask

  task automatic load_flags(input logic [7:0] f);
    flag_we = 1'b1; flag_in = f;
    @(posedge clk); #1;
    flag_we = 1'b0;
    m_flags = f & 8'hD5;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (done) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_done", 16'h1, 16'h0);
        end else begin
          e = sb_q.pop_front();
          check_eq("acc", {8'h0, acc_out}, {8'h0, e.acc});
          check_eq("flags", {8'h0, flags_out}, {8'h0, e.flags});
          check_eq("prod_lo", {8'h0, prod_lo}, {8'h0, e.prod});
          check_eq("latency", 16'(cyc - e.cyc), 16'(e.lat));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 4'd0; src_sel = 1'b0; dbus_in = 8'h00;
    acc_we = 1'b0; flag_we = 1'b0; flag_in = 8'h00;
    #12;
    check_eq("rst_acc", {8'h0, acc_out}, 16'h0);
    check_eq("rst_prod", {8'h0, prod_lo}, 16'h0);
    check_eq("rst_flags", {8'h0, flags_out}, 16'h0);
    check_eq("rst_busy", {15'h0, busy}, 16'h0);
    check_eq("rst_done", {15'h0, done}, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_acc(8'h3A);
    issue(4'd0, 1'b1, 8'hC6);                     // ADD -> 0x00, flags 0x55
    load_acc(8'h05);
    issue(4'd2, 1'b1, 8'h07);                     // SUB -> 0xFE with borrow
    issue(4'd7, 1'b1, 8'hFE);                     // CMP back-to-back, Z=1
    load_acc(8'hFF);
    issue(4'd12, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b1); // MUL with ignored mid-op requests
    load_acc(8'h10);
    issue(4'd1, 1'b1, 8'h20, 1'b1, 8'h01);        // ADC with same-edge flag load -> 0x31
    load_flags(8'hFF);
    check_eq("flags_mask", {8'h0, flags_out}, 16'h00D5);
    load_flags(8'h54);
    load_acc(8'h81);
    issue(4'd10, 1'b1, 8'h00);                    // RRC -> 0xC0, CY=1
    issue(4'd13, 1'b0, 8'h77);                    // NOP
    issue(4'd11, 1'b0, 8'h80);                    // RLC
    issue(4'd8, 1'b0, 8'h0F);                     // INC half-carry
    issue(4'd9, 1'b0, 8'h10);                     // DEC half-borrow

    for (int k = 0; k < 30; k++) begin
      issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Reset in the middle of a multiply: outputs clear at once, no done afterwards.
    load_acc(8'h9C);
    start = 1'b1; op = 4'd12; src_sel = 1'b1; dbus_in = 8'h77;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_acc", {8'h0, acc_out}, 16'h0);
    check_eq("arst_prod", {8'h0, prod_lo}, 16'h0);
    check_eq("arst_flags", {8'h0, flags_out}, 16'h0);
    check_eq("arst_busy", {15'h0, busy}, 16'h0);
    check_eq("arst_done", {15'h0, done}, 16'h0);
    m_acc = 8'h00; m_prod = 8'h00; m_flags = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("post_rst_busy", {15'h0, busy}, 16'h0);
    check_eq("post_rst_acc", {8'h0, acc_out}, 16'h0);

    load_acc(8'h03);
    issue(4'd12, 1'b1, 8'h05);                    // MUL after reset -> 0x000F
    repeat (3) @(posedge clk);
    #1;
    check_eq("queue_empty", 16'(sb_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
